display_timing: RTL and testbench

- Generates 640x480@60 raster timing and feeds pixel coordinates (sx, sy) and data-enable (de) to the renderer.
- Also drives the panel sync signals and per-line / per-frame strobes.
- Counter origin is the start of the back porch. Order along each axis is back porch, active, front porch, sync. The renderer's active-area offsets (sx >= HBP, sy >= VBP) depend on this order.
- Sits between the pixel-clock domain root and the render/output stage.

---
 rtl/display_timing_if.sv | 24 ++
 rtl/display_timing.sv | 101 ++++++++++
 tb/tb_display_timing.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/display_timing_if.sv
// Raster timing bundle: clock enable in, coordinates, video flags, syncs and strobes out.
interface display_timing_if #(
  parameter int unsigned FCW = 16
);
  logic           en;
  logic [9:0]     sx;
  logic [9:0]     sy;
  logic           de;
  logic           hsync;
  logic           vsync;
  logic           line;
  logic           frame;
  logic [FCW-1:0] frame_count;

  modport master (
    input  en,
    output sx, sy, de, hsync, vsync, line, frame, frame_count
  );

  modport slave (
    output en,
    input  sx, sy, de, hsync, vsync, line, frame, frame_count
  );
endinterface

// File: rtl/display_timing.sv
// Raster timing generator: counters start at the back porch (back, active, front, sync);
// all flags are decoded from next-state counters so they align with registered sx/sy.
module display_timing #(
  parameter int unsigned HA_ACTIVE = 640,
  parameter int unsigned H_FRONT   = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BACK    = 48,
  parameter int unsigned VA_ACTIVE = 480,
  parameter int unsigned V_FRONT   = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BACK    = 33,
  parameter int unsigned SYNC_NEG  = 1,
  parameter int unsigned FCW       = 16
) (
  input  logic             clk_pix,
  input  logic             rst_n,
  display_timing_if.master tmg_o
);
  localparam int unsigned CW      = 10;
  localparam int unsigned H_TOTAL = H_BACK + HA_ACTIVE + H_FRONT + H_SYNC;
  localparam int unsigned V_TOTAL = V_BACK + VA_ACTIVE + V_FRONT + V_SYNC;

  localparam logic [CW-1:0] H_MAX  = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_MAX  = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] DE_X0  = CW'(H_BACK);
  localparam logic [CW-1:0] DE_X1  = CW'(H_BACK + HA_ACTIVE);
  localparam logic [CW-1:0] DE_Y0  = CW'(V_BACK);
  localparam logic [CW-1:0] DE_Y1  = CW'(V_BACK + VA_ACTIVE);
  localparam logic [CW-1:0] HS_X0  = CW'(H_BACK + HA_ACTIVE + H_FRONT);
  localparam logic [CW-1:0] VS_Y0  = CW'(V_BACK + VA_ACTIVE + V_FRONT);
  localparam logic          SYNC_ON  = (SYNC_NEG == 0);
  localparam logic          SYNC_OFF = ~SYNC_ON;

  logic [CW-1:0]  sx_q, sx_d;
  logic [CW-1:0]  sy_q, sy_d;
  logic           de_q, de_d;
  logic           hs_q, hs_d;
  logic           vs_q, vs_d;
  logic           line_q, line_d;
  logic           frame_q, frame_d;
  logic [FCW-1:0] fc_q, fc_d;

  // Next-state counters and flag decode; strobes drop and levels hold while disabled.
  always_comb begin
    sx_d    = sx_q;
    sy_d    = sy_q;
    de_d    = de_q;
    hs_d    = hs_q;
    vs_d    = vs_q;
    line_d  = 1'b0;
    frame_d = 1'b0;
    fc_d    = fc_q;
    if (tmg_o.en) begin
      if (sx_q == H_MAX) begin
        sx_d = '0;
        sy_d = (sy_q == V_MAX) ? '0 : sy_q + CW'(1);
      end else begin
        sx_d = sx_q + CW'(1);
      end
      de_d    = (sx_d >= DE_X0) && (sx_d < DE_X1) && (sy_d >= DE_Y0) && (sy_d < DE_Y1);
      hs_d    = (sx_d >= HS_X0) ? SYNC_ON : SYNC_OFF;
      vs_d    = (sy_d >= VS_Y0) ? SYNC_ON : SYNC_OFF;
      line_d  = (sx_d == '0);
      frame_d = line_d && (sy_d == '0);
      if (frame_d) begin
        fc_d = fc_q + FCW'(1);
      end
    end
  end

  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      sx_q    <= '0;
      sy_q    <= '0;
      de_q    <= 1'b0;
      hs_q    <= SYNC_OFF;
      vs_q    <= SYNC_OFF;
      line_q  <= 1'b0;
      frame_q <= 1'b0;
      fc_q    <= '0;
    end else begin
      sx_q    <= sx_d;
      sy_q    <= sy_d;
      de_q    <= de_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      line_q  <= line_d;
      frame_q <= frame_d;
      fc_q    <= fc_d;
    end
  end

  assign tmg_o.sx          = sx_q;
  assign tmg_o.sy          = sy_q;
  assign tmg_o.de          = de_q;
  assign tmg_o.hsync       = hs_q;
  assign tmg_o.vsync       = vs_q;
  assign tmg_o.line        = line_q;
  assign tmg_o.frame       = frame_q;
  assign tmg_o.frame_count = fc_q;
endmodule

// File: tb/tb_display_timing.sv
// Directed bench: a default 640x480 instance (active-low syncs) and a shrunken
// instance with active-high syncs and a 4-bit frame counter for frame-level checks.
module tb_display_timing;
  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;
  always #5 clk = ~clk;

  display_timing_if #(.FCW(16)) ia ();
  display_timing_if #(.FCW(4))  ib ();

  display_timing dut_a (
    .clk_pix (clk),
    .rst_n   (rst_a),
    .tmg_o   (ia)
  );

  // Small raster: H 3+6+2+3 = 14, V 2+3+1+2 = 8, frame = 112 cycles
  display_timing #(
    .HA_ACTIVE(6), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .VA_ACTIVE(3), .V_FRONT(1), .V_SYNC(2), .V_BACK(2),
    .SYNC_NEG(0), .FCW(4)
  ) dut_b (
    .clk_pix (clk),
    .rst_n   (rst_b),
    .tmg_o   (ib)
  );

  logic [41:0] got_a;
  logic [29:0] got_b;
  assign got_a = {ia.frame_count, ia.sx, ia.sy, ia.de, ia.hsync, ia.vsync, ia.line, ia.frame};
  assign got_b = {ib.frame_count, ib.sx, ib.sy, ib.de, ib.hsync, ib.vsync, ib.line, ib.frame};

  int n_cmp = 0;
  int n_bad = 0;
  int ax, ay, bx, by, bfc;

  // Expected packed state of the 640x480 instance (syncs active-low).
  function automatic logic [41:0] exp_a(int x, int y, logic ln);
    logic de, hs, vs;
    de = (x >= 48) && (x < 688) && (y >= 33) && (y < 513);
    hs = !(x >= 704);
    vs = !(y >= 523);
    return {16'd0, 10'(x), 10'(y), de, hs, vs, ln, ln && (y == 0)};
  endfunction

  // Expected packed state of the small instance (syncs active-high).
  function automatic logic [29:0] exp_b(int x, int y, logic ln, int fc);
    logic de, hs, vs;
    de = (x >= 3) && (x < 9) && (y >= 2) && (y < 5);
    hs = (x >= 11);
    vs = (y >= 6);
    return {4'(fc), 10'(x), 10'(y), de, hs, vs, ln, ln && (y == 0)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task adv_a();
    ax = ax + 1;
    if (ax == 800) begin
      ax = 0;
      ay = (ay + 1) % 525;
    end
  endtask

  task adv_b();
    bx = bx + 1;
    if (bx == 14) begin
      bx = 0;
      by = (by + 1) % 8;
      if (by == 0) bfc = (bfc + 1) % 16;
    end
  endtask

  task test_reset();
    rst_a = 1'b0;
    rst_b = 1'b0;
    ia.en = 1'b0;
    ib.en = 1'b0;
    tick();
    tick();
    n_cmp++;
    if (got_a !== exp_a(0, 0, 1'b0)) begin
      n_bad++;
      $display("FAIL reset_a got=%h exp=%h", got_a, exp_a(0, 0, 1'b0));
    end
    n_cmp++;
    if (ia.hsync !== 1'b1 || ia.vsync !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_a_sync got=%b%b exp=11", ia.hsync, ia.vsync);
    end
    n_cmp++;
    if (got_b !== 30'd0) begin
      n_bad++;
      $display("FAIL reset_b got=%h exp=0", got_b);
    end
  endtask

  // One enabled line from (0,0) on instance A; checks every cycle plus line totals.
  task run_line_a(input string nm);
    int hs_low, lines;
    hs_low = 0;
    lines  = 0;
    for (int i = 0; i < 800; i++) begin
      tick();
      adv_a();
      if (ia.hsync === 1'b0) hs_low++;
      if (ia.line === 1'b1) lines++;
      n_cmp++;
      if (got_a !== exp_a(ax, ay, ax == 0)) begin
        n_bad++;
        $display("FAIL %s_cyc%0d got=%h exp=%h", nm, i, got_a, exp_a(ax, ay, ax == 0));
      end
    end
    n_cmp++;
    if (ia.sx !== 10'd0 || ia.sy !== 10'd1) begin
      n_bad++;
      $display("FAIL %s_end got=(%0d,%0d) exp=(0,1)", nm, ia.sx, ia.sy);
    end
    n_cmp++;
    if (hs_low != 96) begin
      n_bad++;
      $display("FAIL %s_hsync_low got=%0d exp=96", nm, hs_low);
    end
    n_cmp++;
    if (lines != 1) begin
      n_bad++;
      $display("FAIL %s_line_count got=%0d exp=1", nm, lines);
    end
  endtask

  task test_first_line();
    ax = 0;
    ay = 0;
    rst_a = 1'b1;
    ia.en = 1'b1;
    run_line_a("first_line");
  endtask

  task test_en_hold();
    for (int i = 0; i < 1000 && ax != 100; i++) begin
      tick();
      adv_a();
    end
    ia.en = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick();
      n_cmp++;
      if (got_a !== exp_a(100, 1, 1'b0)) begin
        n_bad++;
        $display("FAIL hold100_cyc%0d got=%h exp=%h", i, got_a, exp_a(100, 1, 1'b0));
      end
    end
    ia.en = 1'b1;
    tick();
    adv_a();
    n_cmp++;
    if (ia.sx !== 10'd101 || ia.sy !== 10'd1 || ia.line !== 1'b0) begin
      n_bad++;
      $display("FAIL resume got=(%0d,%0d,l%b) exp=(101,1,l0)", ia.sx, ia.sy, ia.line);
    end
    for (int i = 0; i < 1000 && ax != 0; i++) begin
      tick();
      adv_a();
    end
    n_cmp++;
    if (got_a !== exp_a(0, 2, 1'b1)) begin
      n_bad++;
      $display("FAIL wrap_line got=%h exp=%h", got_a, exp_a(0, 2, 1'b1));
    end
    ia.en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_cmp++;
      if (got_a !== exp_a(0, 2, 1'b0)) begin
        n_bad++;
        $display("FAIL hold0_cyc%0d got=%h exp=%h", i, got_a, exp_a(0, 2, 1'b0));
      end
    end
    ia.en = 1'b1;
    tick();
    adv_a();
    n_cmp++;
    if (got_a !== exp_a(1, 2, 1'b0)) begin
      n_bad++;
      $display("FAIL resume0 got=%h exp=%h", got_a, exp_a(1, 2, 1'b0));
    end
  endtask

  task test_mid_reset();
    for (int i = 0; i < 1000 && ax != 300; i++) begin
      tick();
      adv_a();
    end
    #3;
    rst_a = 1'b0;
    #1;
    n_cmp++;
    if (got_a !== exp_a(0, 0, 1'b0)) begin
      n_bad++;
      $display("FAIL async_reset got=%h exp=%h", got_a, exp_a(0, 0, 1'b0));
    end
    tick();
    tick();
    n_cmp++;
    if (got_a !== exp_a(0, 0, 1'b0)) begin
      n_bad++;
      $display("FAIL reset_held got=%h exp=%h", got_a, exp_a(0, 0, 1'b0));
    end
    ax = 0;
    ay = 0;
    rst_a = 1'b1;
    run_line_a("after_reset");
  endtask

  // Seventeen small frames: per-cycle model, de corners, per-frame counts, counter wrap.
  task test_frames_b();
    int xs [6] = '{2, 3, 8, 9, 3, 3};
    int ys [6] = '{2, 2, 4, 4, 5, 1};
    logic ds [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    int de_n, vs_n, hs_n, fr_n, first_fr;
    de_n = 0; vs_n = 0; hs_n = 0; fr_n = 0; first_fr = -1;
    bx = 0; by = 0; bfc = 0;
    rst_b = 1'b1;
    ib.en = 1'b1;
    for (int i = 1; i <= 17 * 112; i++) begin
      tick();
      adv_b();
      n_cmp++;
      if (got_b !== exp_b(bx, by, bx == 0, bfc)) begin
        n_bad++;
        $display("FAIL small_cyc%0d got=%h exp=%h", i, got_b, exp_b(bx, by, bx == 0, bfc));
      end
      if (i <= 112) begin
        if (ib.de === 1'b1) de_n++;
        if (ib.vsync === 1'b1) vs_n++;
        if (ib.hsync === 1'b1) hs_n++;
        if (ib.frame === 1'b1) fr_n++;
        for (int k = 0; k < 6; k++) begin
          if (bx == xs[k] && by == ys[k]) begin
            n_cmp++;
            if (ib.de !== ds[k]) begin
              n_bad++;
              $display("FAIL de_at_%0d_%0d got=%b exp=%b", xs[k], ys[k], ib.de, ds[k]);
            end
          end
        end
      end
      if (ib.frame === 1'b1 && first_fr < 0) first_fr = i;
    end
    n_cmp++;
    if (first_fr != 112) begin
      n_bad++;
      $display("FAIL first_frame got=%0d exp=112", first_fr);
    end
    n_cmp++;
    if (de_n != 18 || vs_n != 28 || hs_n != 24 || fr_n != 1) begin
      n_bad++;
      $display("FAIL frame_counts got=de%0d vs%0d hs%0d fr%0d exp=de18 vs28 hs24 fr1",
               de_n, vs_n, hs_n, fr_n);
    end
    n_cmp++;
    if (ib.frame_count !== 4'd1) begin
      n_bad++;
      $display("FAIL fc_wrap got=%0d exp=1", ib.frame_count);
    end
  endtask

  initial begin
    test_reset();
    test_first_line();
    test_en_hold();
    test_mid_reset();
    ia.en = 1'b0;
    test_frames_b();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
